// File: rtl/mem_pkg.sv
// Shared types and default sizes for the two-client memory read arbiter.
package mem_pkg;
  localparam int ADDR_W_DEF         = 12;
  localparam int DATA_W_DEF         = 16;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef logic [ADDR_W_DEF-1:0] address_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Client and memory handshake bundle; master is the arbiter side, slave the environment.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              c0_req;
  logic              c1_req;
  logic [ADDR_W-1:0] c0_addr;
  logic [ADDR_W-1:0] c1_addr;
  logic              c0_ready;
  logic              c1_ready;
  logic [DATA_W-1:0] c0_data;
  logic [DATA_W-1:0] c1_data;
  logic              c0_err;
  logic              c1_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;

  modport master (
    input  c0_req, c1_req, c0_addr, c1_addr, mem_ready, mem_data,
    output c0_ready, c1_ready, c0_data, c1_data, c0_err, c1_err, mem_req, mem_addr
  );

  modport slave (
    output c0_req, c1_req, c0_addr, c1_addr, mem_ready, mem_data,
    input  c0_ready, c1_ready, c0_data, c1_data, c0_err, c1_err, mem_req, mem_addr
  );
endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: with both requests pending, the client not served last wins.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-client read arbiter in front of a single-outstanding memory port.
// Optional WAIT timeout with error flag is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus,
  output logic          busy,
  output logic          owner
);
  arb_state_t        state;
  logic              grant;
  logic              last;
  logic              owner_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        ready_r;
  logic [DATA_W-1:0] data_r [2];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err_r;
`endif

  arb_rr2 u_rr (
    .req0  (bus.c0_req),
    .req1  (bus.c1_req),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner_r   <= 1'b0;
      mem_req_r <= 1'b0;
      addr_r    <= '0;
      ready_r   <= '0;
      data_r[0] <= '0;
      data_r[1] <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_r     <= '0;
`endif
    end else begin
      mem_req_r <= 1'b0;
      ready_r   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_r     <= '0;
`endif
      case (state)
        IDLE: begin
          if (bus.c0_req || bus.c1_req) begin
            owner_r   <= grant;
            addr_r    <= grant ? bus.c1_addr : bus.c0_addr;
            mem_req_r <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // A response landing on the limit cycle still takes priority over the abort.
          if (bus.mem_ready) begin
            data_r[owner_r]  <= bus.mem_data;
            ready_r[owner_r] <= 1'b1;
            state            <= RESPOND;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            data_r[owner_r]  <= '0;
            ready_r[owner_r] <= 1'b1;
            err_r[owner_r]   <= 1'b1;
            state            <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESPOND: begin
          last  <= owner_r;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign owner        = owner_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = addr_r;
  assign bus.c0_ready = ready_r[0];
  assign bus.c1_ready = ready_r[1];
  assign bus.c0_data  = data_r[0];
  assign bus.c1_data  = data_r[1];
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.c0_err   = err_r[0];
  assign bus.c1_err   = err_r[1];
`else
  assign bus.c0_err   = 1'b0;
  assign bus.c1_err   = 1'b0;
`endif
endmodule
